dcp_print: RTL
==============

Name: dcp_print

Overview:
- Transmit-side formatter for the serial debug unit, and the counterpart of the receive-side scanner.
- Accepts print requests from the debug controller and its command children over the req_tx/type_tx/dout_tx/ack_tx handshake.
- Serialises each request into ASCII bytes on a valid/ready byte stream feeding the UART transmitter.
- Two request types: a raw character, or a 32-bit word printed as hex digits.

Parameters:
- HEX_DIGITS, 8: number of low-order nibbles printed for a hex request, legal range 1..8, most significant printed nibble first.
- UPPER_CASE, 1: 1 prints digits 10..15 as 'A'-'F' (0x41-0x46); 0 prints them as 'a'-'f' (0x61-0x66).

Ports:
- clk  input  1  system clock; the block has one clock.
- rstn  input  1  asynchronous, active-low reset.
- req_tx  input  1  print request, level-sensitive; held until ack_tx is seen.
- type_tx  input  1  request type: 0 = raw char (dout_tx[7:0]), 1 = hex word.
- dout_tx  input  32  data to print; sampled only on request acceptance.
- ack_tx  output  1  one-cycle pulse when the last byte of the request has been accepted downstream.
- d_tx  output  8  byte to UART transmitter.
- vld_tx  output  1  d_tx valid.
- rdy_tx  input  1  UART transmitter ready.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: asynchronous on rstn low, taking effect immediately, including mid-transfer.
  - state=IDLE, d_tx=0x00, vld_tx=0, ack_tx=0, busy=0; internal shift register and counter cleared.
  - A partially sent word is abandoned; nothing resumes after reset.
- All outputs are registered.
- States: IDLE, SEND, ACK, HOLD, plus CR and LF under the optional feature.
- IDLE:
  - On req_tx=1: latch dout_tx and type_tx, load d_tx with the first byte, set vld_tx=1, go to SEND.
  - Latency: the first byte appears on d_tx/vld_tx in the cycle after req_tx is sampled high.
- SEND:
  - A byte transfers on any clock edge where vld_tx && rdy_tx.
  - While vld_tx=1 && rdy_tx=0, d_tx and vld_tx hold steady. This is a hard stability rule.
  - After a transfer, if bytes remain, the next byte is loaded in the same edge and vld_tx stays 1 (throughput 1 byte/cycle with rdy_tx held high).
  - After the transfer of the last byte: vld_tx=0, go to ACK.
- Byte content:
  - type 0: exactly one byte, dout_tx[7:0], passed unmodified (no filtering of control codes).
  - type 1: HEX_DIGITS bytes, nibble HEX_DIGITS-1 down to nibble 0.
  - Nibble n maps to 0x30+n for n<10; for n>=10 it maps to 0x41+(n-10) or 0x61+(n-10) per UPPER_CASE.
  - Leading zeros are printed; 0x0000_0000 prints "00000000".
- Counter: a 4-bit down-counter of remaining bytes. The latched word shifts left 4 bits per transfer. No wrap-around is possible.
- ACK: ack_tx=1 for exactly one cycle, then go to HOLD.
- HOLD:
  - Wait until req_tx=0, then go to IDLE.
  - This prevents a requester that drops req_tx one cycle late from retriggering.
  - A new request therefore needs req_tx low for at least one sampled cycle.
- Input changes:
  - type_tx and dout_tx changes after acceptance are ignored.
  - If req_tx falls mid-transfer, the transfer completes and ack_tx is still issued.

Optional Feature:
- Macro: DCP_PRINT_CRLF_EN.
- Defined:
  - A type 1 request appends 0x0D then 0x0A after the last hex digit, through the CR and LF states, under the same valid/ready rules.
  - ack_tx follows acceptance of 0x0A.
  - type 0 requests are unaffected.
- Undefined: the CR/LF states and their logic are absent; a hex request sends exactly HEX_DIGITS bytes.

Decomposition:
- Shared package dcp_pkg:
  - state encodings for this block;
  - TYPE_CHAR=1'b0 and TYPE_HEX=1'b1;
  - ASCII constants ASC_0 (0x30), ASC_UA (0x41), ASC_LA (0x61), ASC_CR (0x0D), ASC_LF (0x0A).
- One sub-module is natural: hex2ascii, combinational, 4-bit nibble in, 8-bit ASCII out, with an UPPER_CASE parameter.

Test Plan:
- type 1, dout 0x1234ABCD, rdy_tx=1: d_tx sequence 31 32 33 34 41 42 43 44 on 8 consecutive cycles; a single ack_tx pulse; busy falls after req_tx drops.
- type 0, dout 0x0000_0052: a single byte 0x52; ack_tx one cycle after its transfer; no further bytes.
- type 1, dout 0x0000000F, rdy_tx pseudo-random 50%: "0000000F" (30×7, 46); d_tx/vld_tx never change while vld_tx=1 && rdy_tx=0.
- req_tx held high 5 cycles past ack_tx: no second transaction; release for 1 cycle then re-raise with dout 0x9: "00000009" sent once.
- rstn pulsed low after the 3rd byte of 0xDEADBEEF: vld_tx=0 and ack_tx=0 immediately; the next request prints its full word from the first digit.
- With DCP_PRINT_CRLF_EN, type 1, dout 0xA5A5A5A5, UPPER_CASE=0: "a5a5a5a5" then 0D 0A; ack_tx follows 0x0A.

Source files
------------

// File: rtl/dcp_pkg.sv
// Shared definitions for the debug print formatter.
// Optional feature macro: DCP_PRINT_CRLF_EN (adds CR/LF states).
// Holds the FSM encoding, request type codes and ASCII constants.
package dcp_pkg;

`ifdef DCP_PRINT_CRLF_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEND = 3'd1,
    S_ACK  = 3'd2,
    S_HOLD = 3'd3,
    S_CR   = 3'd4,
    S_LF   = 3'd5
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_ACK  = 2'd2,
    S_HOLD = 2'd3
  } state_t;
`endif

  localparam logic TYPE_CHAR = 1'b0;
  localparam logic TYPE_HEX  = 1'b1;

  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_UA = 8'h41;
  localparam logic [7:0] ASC_LA = 8'h61;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;

endpackage

// File: rtl/dcp_print_hex2ascii.sv
// Nibble to ASCII hex digit converter.
// Latency: combinational.
// Backpressure: none (pure function).
module hex2ascii
  import dcp_pkg::*;
#(
  parameter bit UPPER_CASE = 1'b1
) (
  input  logic [3:0] nib_i,
  output logic [7:0] asc_o
);

  // Digits 0-9 start at '0'; 10-15 start at 'A' or 'a'.
  always_comb begin
    if (nib_i < 4'd10) begin
      asc_o = ASC_0 + {4'h0, nib_i};
    end else begin
      asc_o = (UPPER_CASE ? ASC_UA : ASC_LA) + {4'h0, nib_i} - 8'd10;
    end
  end

endmodule

// File: rtl/dcp_print.sv
// Debug print formatter: serialises raw chars or hex words into ASCII bytes.
// Latency: first byte valid the cycle after req_tx is sampled; 1 byte/cycle.
// Backpressure: d_tx/vld_tx hold while rdy_tx is low. Macro DCP_PRINT_CRLF_EN appends CR LF to hex.
module dcp_print
  import dcp_pkg::*;
#(
  parameter int unsigned HEX_DIGITS = 8,
  parameter bit          UPPER_CASE = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_tx,
  input  logic        type_tx,
  input  logic [31:0] dout_tx,
  output logic        ack_tx,
  output logic [7:0]  d_tx,
  output logic        vld_tx,
  input  logic        rdy_tx,
  output logic        busy
);

  // Unprinted high nibbles are shifted out at load so the next digit is always at the top.
  localparam int unsigned SHIFT = 4 * (8 - HEX_DIGITS);

  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  d_q, d_d;
  logic        vld_q, vld_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
`ifdef DCP_PRINT_CRLF_EN
  logic        type_q, type_d;
`endif

  logic [31:0] load_word;
  logic [7:0]  first_hex;
  logic [7:0]  next_hex;
  logic        xfer;

  assign load_word = dout_tx << SHIFT;
  assign xfer      = vld_q && rdy_tx;

  hex2ascii #(.UPPER_CASE(UPPER_CASE)) u_first (
    .nib_i (load_word[31:28]),
    .asc_o (first_hex)
  );

  hex2ascii #(.UPPER_CASE(UPPER_CASE)) u_next (
    .nib_i (word_q[27:24]),
    .asc_o (next_hex)
  );

  // Next-state and registered-output logic of the print FSM.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    vld_d   = vld_q;
    ack_d   = 1'b0;
`ifdef DCP_PRINT_CRLF_EN
    type_d  = type_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_tx) begin
          word_d  = load_word;
          vld_d   = 1'b1;
          state_d = S_SEND;
`ifdef DCP_PRINT_CRLF_EN
          type_d  = type_tx;
`endif
          if (type_tx == TYPE_HEX) begin
            d_d   = first_hex;
            cnt_d = 4'(HEX_DIGITS);
          end else begin
            d_d   = dout_tx[7:0];
            cnt_d = 4'd1;
          end
        end
      end
      S_SEND: begin
        if (xfer) begin
          if (cnt_q == 4'd1) begin
            cnt_d   = 4'd0;
            vld_d   = 1'b0;
            ack_d   = 1'b1;
            state_d = S_ACK;
`ifdef DCP_PRINT_CRLF_EN
            if (type_q == TYPE_HEX) begin
              vld_d   = 1'b1;
              ack_d   = 1'b0;
              d_d     = ASC_CR;
              state_d = S_CR;
            end
`endif
          end else begin
            cnt_d  = cnt_q - 4'd1;
            word_d = word_q << 4;
            d_d    = next_hex;
          end
        end
      end
`ifdef DCP_PRINT_CRLF_EN
      S_CR: begin
        if (xfer) begin
          d_d     = ASC_LF;
          state_d = S_LF;
        end
      end
      S_LF: begin
        if (xfer) begin
          vld_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = S_ACK;
        end
      end
`endif
      S_ACK: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        // A late-dropping requester must not retrigger.
        if (!req_tx) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        vld_d   = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      d_q     <= '0;
      vld_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef DCP_PRINT_CRLF_EN
      type_q  <= TYPE_CHAR;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      vld_q   <= vld_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
`ifdef DCP_PRINT_CRLF_EN
      type_q  <= type_d;
`endif
    end
  end

  assign d_tx   = d_q;
  assign vld_tx = vld_q;
  assign ack_tx = ack_q;
  assign busy   = busy_q;

endmodule
